// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared pattern-mode and bounce-direction constants for led_chaser
package led_pkg;

  localparam logic [1:0] MODE_ROL    = 2'd0;
  localparam logic [1:0] MODE_ROR    = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_FILL   = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_prescaler.sv
// rtl/led_prescaler.sv - programmable step prescaler, one tick every div+1 enabled cycles
module led_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // >= rather than == so that lowering div below cnt fires at once instead of wrapping
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q >= div) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - running-light generator: rotate left/right, bounce and bar fill patterns
module led_chaser #(
  parameter int LED_W = 8,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
  output logic [LED_W-1:0] led,
  output logic             step
);

  import led_pkg::*;

  logic             tick;
  logic [LED_W-1:0] led_q;
  logic [LED_W-1:0] led_d;
  logic             dir_q;
  logic             dir_d;
  logic             step_q;
  logic             step_d;
  logic             bar_ok;
  logic             one_hot;

  led_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .div   (div),
    .tick  (tick)
  );

  assign bar_ok  = ((led_q & (led_q + LED_W'(1))) == '0);
  assign one_hot = ($countones(led_q) == 1);

  always_comb begin
    led_d  = led_q;
    dir_d  = dir_q;
    step_d = tick;
    if (tick) begin
      if (mode == MODE_FILL) begin
        // an all-ones bar also empties, so both cases clear the bank
        if (!bar_ok || (&led_q)) begin
          led_d = '0;
        end else begin
          led_d = {led_q[LED_W-2:0], 1'b1};
        end
      end else if (!one_hot) begin
        led_d = LED_W'(1);
        dir_d = DIR_LEFT;
      end else begin
        case (mode)
          MODE_ROL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
          MODE_ROR: led_d = {led_q[0], led_q[LED_W-1:1]};
          default: begin
            // bounce turns around on the end LED itself, so each end is lit once per pass
            if (dir_q == DIR_LEFT && led_q[LED_W-1]) begin
              dir_d = DIR_RIGHT;
              led_d = {1'b0, led_q[LED_W-1:1]};
            end else if (dir_q == DIR_RIGHT && led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = {led_q[LED_W-2:0], 1'b0};
            end else if (dir_q == DIR_LEFT) begin
              led_d = {led_q[LED_W-2:0], 1'b0};
            end else begin
              led_d = {1'b0, led_q[LED_W-1:1]};
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q  <= LED_W'(1);
      dir_q  <= DIR_LEFT;
      step_q <= 1'b0;
    end else begin
      led_q  <= led_d;
      dir_q  <= dir_d;
      step_q <= step_d;
    end
  end

  assign led  = led_q;
  assign step = step_q;

endmodule

// File: tb/tb_led_chaser.sv
// tb/tb_led_chaser.sv - randomized and directed self-checking bench for led_chaser
module tb_led_chaser;

  localparam int W  = 8;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic [DW-1:0] div;
  logic [W-1:0]  led;
  logic          step;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] m_led;
  logic         m_dir;
  int           m_cnt = 0;
  logic         m_step;

  led_chaser #(
    .LED_W (W),
    .DIV_W (DW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .div   (div),
    .led   (led),
    .step  (step)
  );

  always #5 clk = ~clk;

  // pattern rules worked on the lit-LED index / bar length rather than on bit vectors
  function automatic void model_next(input logic [W-1:0] l, input logic d, input logic [1:0] md,
                                     output logic [W-1:0] nl, output logic nd);
    int k;
    int n;
    nl = l;
    nd = d;
    if (md == 2'd3) begin
      n = $countones(l);
      if (int'(l) != (1 << n) - 1) nl = '0;
      else if (n == W)             nl = '0;
      else                         nl = W'((1 << (n + 1)) - 1);
    end else if ($countones(l) != 1) begin
      nl = W'(1);
      nd = 1'b0;
    end else begin
      k = 0;
      for (int i = 0; i < W; i++) if (l[i]) k = i;
      case (md)
        2'd0: k = (k + 1) % W;
        2'd1: k = (k + W - 1) % W;
        default: begin
          if (!d && k == W - 1) nd = 1'b1;
          else if (d && k == 0) nd = 1'b0;
          k = nd ? k - 1 : k + 1;
        end
      endcase
      nl = W'(1 << k);
    end
  endfunction

  task automatic clk_step();
    logic         tk;
    logic [W-1:0] nl;
    logic         nd;
    @(posedge clk);
    if (!rst_n) begin
      m_led  = W'(1);
      m_dir  = 1'b0;
      m_cnt  = 0;
      m_step = 1'b0;
    end else if (!en) begin
      m_step = 1'b0;
    end else begin
      tk     = (m_cnt >= int'(div));
      m_cnt  = tk ? 0 : m_cnt + 1;
      m_step = tk;
      if (tk) begin
        model_next(m_led, m_dir, mode, nl, nd);
        m_led = nl;
        m_dir = nd;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    repeat (3) clk_step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    mode  = 2'd0;
    div   = '0;
    repeat (3) clk_step();
    total++;
    if (led !== 8'h01) begin
      bad++;
      $display("FAIL reset_led: got %h want 01", led);
    end
    total++;
    if (step !== 1'b0) begin
      bad++;
      $display("FAIL reset_step: got %b want 0", step);
    end
    rst_n = 1'b1;
    en    = 1'b0;
    for (int i = 0; i < 20; i++) begin
      clk_step();
      total++;
      if (led !== 8'h01 || step !== 1'b0) begin
        bad++;
        $display("FAIL hold_en0 cyc %0d: led=%h step=%b want led=01 step=0", i, led, step);
      end
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_seq [2][9];
    exp_seq[0] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    exp_seq[1] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
    for (int md = 0; md < 2; md++) begin
      do_reset();
      mode = 2'(md);
      div  = DW'(3);
      en   = 1'b1;
      for (int i = 0; i < 9; i++) begin
        for (int c = 0; c < 4; c++) begin
          clk_step();
          total++;
          if (led !== m_led || step !== m_step) begin
            bad++;
            $display("FAIL rotate%0d_model: led=%h step=%b want led=%h step=%b", md, led, step, m_led, m_step);
          end
        end
        total++;
        if (step !== 1'b1 || led !== exp_seq[md][i]) begin
          bad++;
          $display("FAIL rotate%0d_seq %0d: led=%h step=%b want led=%h step=1", md, i, led, step, exp_seq[md][i]);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] exp_seq [14];
    exp_seq = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    do_reset();
    mode = 2'd2;
    div  = '0;
    en   = 1'b1;
    for (int i = 0; i < 29; i++) begin
      clk_step();
      total++;
      if (led !== exp_seq[i % 14] || step !== 1'b1 || led !== m_led) begin
        bad++;
        $display("FAIL bounce %0d: led=%h step=%b want led=%h step=1", i, led, step, exp_seq[i % 14]);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] exp_seq [9];
    exp_seq = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h00, 8'h01};
    do_reset();
    mode = 2'd3;
    div  = '0;
    en   = 1'b1;
    for (int i = 0; i < 18; i++) begin
      clk_step();
      total++;
      if (led !== exp_seq[i % 9] || step !== 1'b1 || led !== m_led) begin
        bad++;
        $display("FAIL fill %0d: led=%h step=%b want led=%h step=1", i, led, step, exp_seq[i % 9]);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    exp_a = '{8'h07, 8'h01, 8'h02};
    exp_b = '{8'h10, 8'h00, 8'h01};
    do_reset();
    mode = 2'd3;
    div  = '0;
    en   = 1'b1;
    clk_step();
    for (int i = 0; i < 3; i++) begin
      clk_step();
      total++;
      if (led !== exp_a[i] || led !== m_led) begin
        bad++;
        $display("FAIL fill_to_rol %0d: led=%h want %h", i, led, exp_a[i]);
      end
      mode = 2'd0;
    end
    do_reset();
    mode = 2'd0;
    en   = 1'b1;
    repeat (3) clk_step();
    for (int i = 0; i < 3; i++) begin
      clk_step();
      total++;
      if (led !== exp_b[i] || led !== m_led) begin
        bad++;
        $display("FAIL rol_to_fill %0d: led=%h want %h", i, led, exp_b[i]);
      end
      mode = 2'd3;
    end
  endtask

  task automatic test_prescaler_edges();
    int  n;
    bit  found;
    do_reset();
    mode = 2'd0;
    div  = DW'(9);
    en   = 1'b1;
    repeat (5) clk_step();
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      clk_step();
      total++;
      if (step !== 1'b0 || led !== 8'h01) begin
        bad++;
        $display("FAIL en_hold %0d: led=%h step=%b want led=01 step=0", i, led, step);
      end
    end
    en    = 1'b1;
    n     = 0;
    found = 1'b0;
    while (!found && n < 20) begin
      clk_step();
      n++;
      if (step === 1'b1) found = 1'b1;
    end
    total++;
    if (!found || n != 5 || step !== m_step || led !== 8'h02) begin
      bad++;
      $display("FAIL resume_tick: step after %0d edges led=%h want 5 edges led=02", n, led);
    end
    do_reset();
    div = DW'(9);
    en  = 1'b1;
    repeat (7) clk_step();
    div = DW'(2);
    clk_step();
    total++;
    if (step !== 1'b1 || led !== 8'h02 || step !== m_step) begin
      bad++;
      $display("FAIL div_lowered: step=%b led=%h want step=1 led=02", step, led);
    end
  endtask

  task automatic test_midrun_reset();
    do_reset();
    mode = 2'd2;
    div  = DW'(1);
    en   = 1'b1;
    repeat (11) clk_step();
    rst_n = 1'b0;
    clk_step();
    total++;
    if (led !== 8'h01 || step !== 1'b0) begin
      bad++;
      $display("FAIL midrun_reset: led=%h step=%b want led=01 step=0", led, step);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      clk_step();
      total++;
      if (led !== m_led || step !== m_step) begin
        bad++;
        $display("FAIL after_reset %0d: led=%h step=%b want led=%h step=%b", i, led, step, m_led, m_step);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    mode = 2'd0;
    div  = '0;
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      en    = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) div = DW'($urandom_range(0, 5));
      clk_step();
      total++;
      if (led !== m_led || step !== m_step) begin
        bad++;
        $display("FAIL random %0d: led=%h step=%b want led=%h step=%b", i, led, step, m_led, m_step);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'd0;
    div   = '0;
    test_reset();
    test_rotate();
    test_bounce();
    test_fill();
    test_mode_switch();
    test_prescaler_edges();
    test_midrun_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
